apb_multi_slave_mem: RTL and testbench

//  Synthesizable APB4 completer bank. It generalises the single-slave APB agent settings to NO_OF_SLAVES

---
 rtl/apb_multi_slave_mem_if.sv | 29 ++
 rtl/apb_multi_slave_mem.sv | 150 +++++++++++++++
 tb/tb_apb_multi_slave_mem.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_multi_slave_mem_if.sv
// APB4 bus bundle between a requester and the multi-bank completer memory.
interface apb_multi_slave_mem_if #(
  parameter int unsigned NO_OF_SLAVES  = 1,
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32
);
  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  logic [NO_OF_SLAVES-1:0]  pselx;
  logic                     penable;
  logic                     pwrite;
  logic [ADDRESS_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0]    pwdata;
  logic [STRB_W-1:0]        pstrb;
  logic [2:0]               pprot;
  logic                     pready;
  logic [DATA_WIDTH-1:0]    prdata;
  logic                     pslverr;

  modport master (
    output pselx, penable, pwrite, paddr, pwdata, pstrb, pprot,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  pselx, penable, pwrite, paddr, pwdata, pstrb, pprot,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/apb_multi_slave_mem.sv
// APB4 completer bank: NO_OF_SLAVES word memories, one per pselx bit, with
// per-transfer wait states, byte strobes and PSLVERR.
// Optional macro APB_PROT_CHECK_EN adds pprot-based access restriction.
module apb_multi_slave_mem #(
  parameter int unsigned NO_OF_SLAVES  = 1,
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned MEM_DEPTH     = 16,
  parameter int unsigned WAIT_W        = 4
) (
  input  logic                      pclk,
  input  logic                      preset_n,
  input  logic [WAIT_W-1:0]         cfg_wait,
  apb_multi_slave_mem_if.slave      bus
);
  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned LSB_W  = $clog2(STRB_W);
  localparam int unsigned IDX_W  = $clog2(MEM_DEPTH);
  localparam int unsigned BANK_W = (NO_OF_SLAVES > 1) ? $clog2(NO_OF_SLAVES) : 1;

  typedef enum logic {IDLE, ACCESS} state_e;

  state_e                    state_q, state_d;
  logic [NO_OF_SLAVES-1:0]   sel_q, sel_d;
  logic [BANK_W-1:0]         bank_q, bank_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic                      wr_q, wr_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [STRB_W-1:0]         strb_q, strb_d;
  logic                      err_q, err_d;
  logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
  logic [WAIT_W-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]     mem_q [NO_OF_SLAVES][MEM_DEPTH];
  logic [DATA_WIDTH-1:0]     mem_d [NO_OF_SLAVES][MEM_DEPTH];

  logic [BANK_W-1:0]         bank_c;
  logic [IDX_W-1:0]          idx_c;
  logic                      prot_err_c;
  logic                      err_c;
  logic                      abort_c;
  logic                      complete_c;

  // Decode the setup-phase address and select into bank, word index and error.
  always_comb begin
    bank_c = '0;
    for (int unsigned i = 0; i < NO_OF_SLAVES; i++) begin
      if (bus.pselx[i]) bank_c = BANK_W'(i);
    end
    idx_c = bus.paddr[LSB_W +: IDX_W];
    err_c = ($countones(bus.pselx) != 1)
         || ((bus.paddr & ADDRESS_WIDTH'(STRB_W - 1)) != '0)
         || ((bus.paddr >> (LSB_W + IDX_W)) != '0)
         || (!bus.pwrite && (bus.pstrb != '0))
         || prot_err_c;
  end

`ifdef APB_PROT_CHECK_EN
  // Unprivileged or non-secure requests may not write, nor read the upper half.
  always_comb begin
    prot_err_c = (!bus.pprot[0] || bus.pprot[1]) && (bus.pwrite || idx_c[IDX_W-1]);
  end
`else
  logic unused_pprot_c;
  assign unused_pprot_c = ^bus.pprot;
  assign prot_err_c     = 1'b0;
`endif

  // Access phase is cut short when the requester drops penable or changes select.
  assign abort_c    = (bus.pselx != sel_q) || !bus.penable;
  assign complete_c = (state_q == ACCESS) && !abort_c && (cnt_q == '0);

  assign bus.pready  = complete_c;
  assign bus.pslverr = complete_c && err_q;
  assign bus.prdata  = (complete_c && !wr_q) ? rdata_q : '0;

  // Next-state: capture in setup, count wait states, commit writes on completion.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    bank_d  = bank_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    mem_d   = mem_q;
    unique case (state_q)
      IDLE: begin
        if ((bus.pselx != '0) && !bus.penable) begin
          sel_d   = bus.pselx;
          bank_d  = bank_c;
          idx_d   = idx_c;
          wr_d    = bus.pwrite;
          wdata_d = bus.pwdata;
          strb_d  = bus.pstrb;
          err_d   = err_c;
          rdata_d = err_c ? '0 : mem_q[bank_c][idx_c];
          cnt_d   = cfg_wait;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (abort_c) begin
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - WAIT_W'(1);
        end else begin
          state_d = IDLE;
          if (wr_q && !err_q) begin
            for (int unsigned i = 0; i < STRB_W; i++) begin
              if (strb_q[i]) mem_d[bank_q][idx_q][8*i +: 8] = wdata_q[8*i +: 8];
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, transfer context and memory registers.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      bank_q  <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      cnt_q   <= '0;
      mem_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      bank_q  <= bank_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      mem_q   <= mem_d;
    end
  end
endmodule

// File: tb/tb_apb_multi_slave_mem.sv
// Directed bench for apb_multi_slave_mem with two banks; a transaction-level
// model predicts every cycle's pready/pslverr/prdata.
module tb_apb_multi_slave_mem;
  localparam int unsigned NS = 2;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned MD = 16;
  localparam int unsigned WW = 4;

  logic          pclk = 1'b0;
  logic          preset_n;
  logic [WW-1:0] cfg_wait;

  apb_multi_slave_mem_if #(.NO_OF_SLAVES(NS), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  apb_multi_slave_mem #(
    .NO_OF_SLAVES(NS), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(MD), .WAIT_W(WW)
  ) dut (
    .pclk(pclk), .preset_n(preset_n), .cfg_wait(cfg_wait), .bus(bus)
  );

  always #5 pclk = ~pclk;

  int n_cmp = 0;
  int n_bad = 0;

  logic        exp_pready;
  logic        exp_pslverr;
  logic [31:0] exp_prdata;

  logic [31:0] model_mem [NS][MD];

  logic [31:0] last_rdata;
  logic        last_err;
  int          rdy_cycle;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of the completer outputs with the model's expectation.
  always @(negedge pclk) begin
    check("pready",  32'(bus.pready),  32'(exp_pready));
    check("pslverr", 32'(bus.pslverr), 32'(exp_pslverr));
    check("prdata",  bus.prdata,       exp_prdata);
  end

  function automatic bit model_err(input logic [1:0] sel, input bit wr, input logic [31:0] addr,
                                   input logic [3:0] strb, input logic [2:0] prot);
    if ($countones(sel) != 1) return 1'b1;
    if (addr % 4 != 0)        return 1'b1;
    if (addr >= MD * 4)       return 1'b1;
    if (!wr && strb != 4'h0)  return 1'b1;
`ifdef APB_PROT_CHECK_EN
    if ((!prot[0] || prot[1]) && (wr || (addr / 4) >= MD / 2)) return 1'b1;
`else
    if (prot == 3'b111 && 1'b0) return 1'b1;
`endif
    return 1'b0;
  endfunction

  task automatic clear_model();
    foreach (model_mem[b, w]) model_mem[b][w] = 32'h0;
  endtask

  task automatic exp_idle();
    exp_pready  = 1'b0;
    exp_pslverr = 1'b0;
    exp_prdata  = 32'h0;
  endtask

  task automatic bus_idle();
    bus.pselx   = '0;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b0;
    bus.paddr   = '0;
    bus.pwdata  = '0;
    bus.pstrb   = '0;
    bus.pprot   = 3'b001;
    exp_idle();
  endtask

  // One APB transfer; drop_at >= 0 lowers penable in that access cycle.
  task automatic xfer(input logic [1:0] sel, input bit wr, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] strb, input logic [2:0] prot,
                      input int wt, input int drop_at, input bit mid_cfg);
    bit          err;
    int          bank;
    int          idx;
    logic [31:0] word;
    err  = model_err(sel, wr, addr, strb, prot);
    bank = (sel == 2'b10) ? 1 : 0;
    idx  = int'((addr / 4) % MD);
    word = err ? 32'h0 : model_mem[bank][idx];
    rdy_cycle  = 0;
    last_rdata = 32'hxxxxxxxx;
    last_err   = 1'bx;
    bus.pselx   = sel;
    bus.penable = 1'b0;
    bus.pwrite  = wr;
    bus.paddr   = addr;
    bus.pwdata  = data;
    bus.pstrb   = strb;
    bus.pprot   = prot;
    cfg_wait    = WW'(wt);
    exp_idle();
    @(posedge pclk); #1;
    bus.penable = 1'b1;
    if (mid_cfg) cfg_wait = '0;
    for (int k = 0; k <= wt; k++) begin
      if (k == drop_at) begin
        bus.penable = 1'b0;
        exp_idle();
        @(posedge pclk); #1;
        bus_idle();
        return;
      end
      if (k < wt) begin
        exp_idle();
      end else begin
        exp_pready  = 1'b1;
        exp_pslverr = err;
        exp_prdata  = wr ? 32'h0 : word;
      end
      @(negedge pclk);
      if (bus.pready && rdy_cycle == 0) begin
        rdy_cycle  = k + 1;
        last_rdata = bus.prdata;
        last_err   = bus.pslverr;
      end
      @(posedge pclk); #1;
    end
    if (wr && !err) begin
      for (int i = 0; i < 4; i++) begin
        if (strb[i]) model_mem[bank][idx][8*i +: 8] = data[8*i +: 8];
      end
    end
    bus_idle();
  endtask

  task automatic wr_w(input logic [1:0] sel, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] strb);
    xfer(sel, 1'b1, addr, data, strb, 3'b001, 0, -1, 1'b0);
  endtask

  task automatic rd_w(input logic [1:0] sel, input logic [31:0] addr);
    xfer(sel, 1'b0, addr, 32'h0, 4'h0, 3'b001, 0, -1, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    preset_n = 1'b0;
    cfg_wait = '0;
    bus_idle();
    clear_model();
    repeat (3) @(posedge pclk);
    #1 preset_n = 1'b1;
    @(posedge pclk); #1;

    // Reset contents read back as zero.
    rd_w(2'b01, 32'h0);
    check("t0_rst_word", last_rdata, 32'h0);

    // Zero-wait write then read-back.
    wr_w(2'b01, 32'h4, 32'hDEADBEEF, 4'hF);
    check("t1_wr_lat", 32'(rdy_cycle), 32'd1);
    check("t1_wr_err", 32'(last_err), 32'd0);
    rd_w(2'b01, 32'h4);
    check("t1_rd_data", last_rdata, 32'hDEADBEEF);
    check("t1_rd_lat", 32'(rdy_cycle), 32'd1);

    // Partial byte-lane write merges with the old word.
    wr_w(2'b01, 32'h8, 32'h11223344, 4'hF);
    wr_w(2'b01, 32'h8, 32'hAABBCCDD, 4'b0101);
    rd_w(2'b01, 32'h8);
    check("t2_strb_merge", last_rdata, 32'h11BB33DD);
    check("t2_model_pin", model_mem[0][2], 32'h11BB33DD);

    // Three wait states; lowering cfg_wait mid-transfer changes nothing.
    xfer(2'b01, 1'b0, 32'h4, 32'h0, 4'h0, 3'b001, 3, -1, 1'b1);
    check("t3_lat", 32'(rdy_cycle), 32'd4);
    check("t3_data", last_rdata, 32'hDEADBEEF);

    // Error cases leave memory unchanged and return zero data.
    wr_w(2'b01, 32'h2, 32'h55555555, 4'hF);
    check("t4_misalign_err", 32'(last_err), 32'd1);
    wr_w(2'b01, 32'h40, 32'h66666666, 4'hF);
    check("t4_oor_err", 32'(last_err), 32'd1);
    wr_w(2'b11, 32'h4, 32'h77777777, 4'hF);
    check("t4_multisel_err", 32'(last_err), 32'd1);
    xfer(2'b01, 1'b0, 32'h4, 32'h0, 4'hF, 3'b001, 0, -1, 1'b0);
    check("t4_rdstrb_err", 32'(last_err), 32'd1);
    check("t4_rdstrb_data", last_rdata, 32'h0);
    rd_w(2'b01, 32'h0);
    check("t4_word0", last_rdata, 32'h0);
    rd_w(2'b01, 32'h4);
    check("t4_word1", last_rdata, 32'hDEADBEEF);
    rd_w(2'b11, 32'h4);
    check("t4_multisel_rd", last_rdata, 32'h0);

    // Second bank is independent; zero-strobe write is legal and inert.
    wr_w(2'b10, 32'h4, 32'hCAFEF00D, 4'hF);
    rd_w(2'b10, 32'h4);
    check("t4_bank1", last_rdata, 32'hCAFEF00D);
    wr_w(2'b01, 32'h4, 32'h12345678, 4'h0);
    check("t4_nostrb_err", 32'(last_err), 32'd0);
    rd_w(2'b01, 32'h4);
    check("t4_bank0", last_rdata, 32'hDEADBEEF);

    // Abort by dropping penable during a waited write.
    xfer(2'b01, 1'b1, 32'h4, 32'h12345678, 4'hF, 3'b001, 2, 1, 1'b0);
    rd_w(2'b01, 32'h4);
    check("t5_abort_keep", last_rdata, 32'hDEADBEEF);

    // Reset during the completing access cycle.
    bus.pselx   = 2'b01;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b1;
    bus.paddr   = 32'h4;
    bus.pwdata  = 32'h99999999;
    bus.pstrb   = 4'hF;
    cfg_wait    = '0;
    exp_idle();
    @(posedge pclk); #1;
    bus.penable = 1'b1;
    #1 preset_n = 1'b0;
    clear_model();
    @(posedge pclk); #1;
    bus_idle();
    preset_n = 1'b1;
    @(posedge pclk); #1;
    rd_w(2'b01, 32'h4);
    check("t5_rst_clear0", last_rdata, 32'h0);
    rd_w(2'b10, 32'h4);
    check("t5_rst_clear1", last_rdata, 32'h0);
    wr_w(2'b01, 32'h10, 32'h0BADF00D, 4'hF);
    rd_w(2'b01, 32'h10);
    check("t5_after_rst", last_rdata, 32'h0BADF00D);

    // Protection attributes: non-secure write, lower and upper half reads.
    xfer(2'b01, 1'b1, 32'hC, 32'h00000077, 4'hF, 3'b010, 0, -1, 1'b0);
`ifdef APB_PROT_CHECK_EN
    check("t6_prot_wr_err", 32'(last_err), 32'd1);
`else
    check("t6_prot_wr_err", 32'(last_err), 32'd0);
`endif
    xfer(2'b01, 1'b0, 32'hC, 32'h0, 4'h0, 3'b010, 0, -1, 1'b0);
    check("t6_prot_rd_lo_err", 32'(last_err), 32'd0);
`ifdef APB_PROT_CHECK_EN
    check("t6_prot_rd_lo_data", last_rdata, 32'h0);
`else
    check("t6_prot_rd_lo_data", last_rdata, 32'h00000077);
`endif
    xfer(2'b01, 1'b0, 32'h28, 32'h0, 4'h0, 3'b010, 0, -1, 1'b0);
`ifdef APB_PROT_CHECK_EN
    check("t6_prot_rd_hi_err", 32'(last_err), 32'd1);
`else
    check("t6_prot_rd_hi_err", 32'(last_err), 32'd0);
`endif

    repeat (2) @(posedge pclk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
